req2axi_master: RTL and testbench

REQ2AXI_MASTER -- requirements
Module: req2axi_master
Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 ADDR_WIDTH, 32, address width.
REQ-003 DATA_WIDTH, 32, data width.
REQ-004 TIMEOUT_CYCLES, 256, response watchdog limit in cycles; legal range 1 to 65535.
REQ-005 i_w_aclk  in  1  clock; all logic on rising edge.
REQ-006 i_w_areset  in  1  synchronous active-high reset.
REQ-007 i_w_req_valid  in  1  request valid.
REQ-008 o_w_req_ready  out  1  request accepted when high with valid.
REQ-009 i_w_req_we  in  1  1=write, 0=read.
REQ-010 i_w_req_addr  in  ADDR_WIDTH  request address.
REQ-011 i_w_req_wdata  in  DATA_WIDTH  write data.
REQ-012 o_w_rsp_valid  out  1  response valid.
REQ-013 i_w_rsp_ready  in  1  response consumed.
REQ-014 o_w_rsp_resp  out  2  AXI response code.
REQ-015 o_w_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-016 o_w_awvalid / i_w_awready / o_w_awaddr[ADDR_WIDTH]  AXI4-Lite AW channel, master side.
REQ-017 o_w_wvalid / i_w_wready / o_w_wdata[DATA_WIDTH]  AXI4-Lite W channel, master side.
REQ-018 i_w_bvalid / o_w_bready / i_w_bresp[2]  AXI4-Lite B channel, master side.
REQ-019 o_w_arvalid / i_w_arready / o_w_araddr[ADDR_WIDTH]  AXI4-Lite AR channel, master side.
REQ-020 i_w_rvalid / o_w_rready / i_w_rresp[2] / i_w_rdata[DATA_WIDTH]  AXI4-Lite R channel, master side.
Function
REQ-021 The block SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP, with one transaction outstanding at most.
REQ-022 o_w_req_ready SHALL be 1 only in IDLE; on handshake, addr/wdata/we SHALL be latched and the FSM SHALL go to WR_REQ (we=1) or RD_REQ (we=0).
REQ-023 In WR_REQ, awvalid and wvalid SHALL both be asserted from the first cycle.
REQ-024 In WR_REQ, each of awvalid and wvalid SHALL drop independently after its own handshake.
REQ-025 The FSM SHALL leave WR_REQ for WR_RESP once both handshakes are done, including both in the same cycle.
REQ-026 awaddr/wdata SHALL stay stable while their valid is high.
REQ-027 WR_RESP: bready SHALL be 1; on bvalid, bresp SHALL be captured, rdata set to 0, and the FSM SHALL go to RSP.
REQ-028 RD_REQ: arvalid SHALL be 1 until arready, then the FSM SHALL go to RD_DATA; araddr SHALL stay stable.
REQ-029 RD_DATA: rready SHALL be 1; on rvalid, rdata/rresp SHALL be captured and the FSM SHALL go to RSP.
REQ-030 RSP: o_w_rsp_valid SHALL be 1 with stable resp/rdata until i_w_rsp_ready, then the FSM SHALL go to IDLE; the next request SHALL be accepted no earlier than the following cycle.
REQ-031 Minimum latency from request accept to rsp_valid SHALL be 3 cycles when all slave readies and valids are immediate.
REQ-032 Addresses and data SHALL pass through unmodified; no alignment checks, no strobes.
Reset
REQ-033 While i_w_areset is high at a clock edge: FSM=IDLE, all valid/ready outputs=0, o_w_rsp_resp=0, o_w_rsp_rdata=0, timeout counter=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction without a response.
Configuration
REQ-035 With REQ2AXI_TIMEOUT_EN defined, a counter SHALL run in WR_RESP/RD_DATA; if TIMEOUT_CYCLES cycles pass with no bvalid/rvalid, bready/rready SHALL drop, rsp_resp SHALL be 2'b11, rdata 0, and the FSM SHALL go to RSP.
REQ-036 The counter SHALL clear on entry to WR_RESP/RD_DATA; without the macro there SHALL be no counter and the block SHALL wait indefinitely.
Verification
REQ-037 Write 0x10 data 0xDEADBEEF, zero-wait slave -> one AW+W handshake with those values, rsp_resp=0, rdata=0, rsp_valid 3 cycles after accept.
REQ-038 Read 0x10 after that write -> araddr=0x10, rsp_rdata=0xDEADBEEF, rsp_resp=0.
REQ-039 Write with wready delayed 4 cycles after awready -> awvalid drops after its handshake, wvalid held, exactly one of each handshake.
REQ-040 i_w_rsp_ready held low 5 cycles -> rsp_valid/data stable, req_ready=0 throughout.
REQ-041 Reset asserted in RD_DATA -> all outputs 0 next cycle; next request completes normally.
REQ-042 REQ2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=8, bvalid never asserted -> rsp_resp=2'b11 after 8 cycles in WR_RESP.

---
 rtl/req2axi_master.sv | 178 +++++++++++++++++
 tb/tb_req2axi_master.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req2axi_master.sv
// Request/response to AXI4-Lite master bridge with one transaction outstanding.
// Define REQ2AXI_TIMEOUT_EN to add a B/R response watchdog of TIMEOUT_CYCLES cycles.
module req2axi_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  i_w_aclk,
   input  logic                  i_w_areset,
   input  logic                  i_w_req_valid,
   output logic                  o_w_req_ready,
   input  logic                  i_w_req_we,
   input  logic [ADDR_WIDTH-1:0] i_w_req_addr,
   input  logic [DATA_WIDTH-1:0] i_w_req_wdata,
   output logic                  o_w_rsp_valid,
   input  logic                  i_w_rsp_ready,
   output logic [1:0]            o_w_rsp_resp,
   output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
   output logic                  o_w_awvalid,
   input  logic                  i_w_awready,
   output logic [ADDR_WIDTH-1:0] o_w_awaddr,
   output logic                  o_w_wvalid,
   input  logic                  i_w_wready,
   output logic [DATA_WIDTH-1:0] o_w_wdata,
   input  logic                  i_w_bvalid,
   output logic                  o_w_bready,
   input  logic [1:0]            i_w_bresp,
   output logic                  o_w_arvalid,
   input  logic                  i_w_arready,
   output logic [ADDR_WIDTH-1:0] o_w_araddr,
   input  logic                  i_w_rvalid,
   output logic                  o_w_rready,
   input  logic [1:0]            i_w_rresp,
   input  logic [DATA_WIDTH-1:0] i_w_rdata
);

   typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdData, StRsp} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  timeout;

`ifdef REQ2AXI_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;

   // Any cycle outside the wait states zeroes the count, so it restarts on every entry.
   always_comb begin
      tmo_d = '0;
      if ((state_q == StWrResp) || (state_q == StRdData)) begin
         tmo_d = tmo_q + 16'd1;
      end
   end

   assign timeout = (tmo_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_w_aclk) begin
      if (i_w_areset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout               = 1'b0;
`endif

   assign o_w_awaddr    = addr_q;
   assign o_w_araddr    = addr_q;
   assign o_w_wdata     = wdata_q;
   assign o_w_rsp_resp  = resp_q;
   assign o_w_rsp_rdata = rdata_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      o_w_req_ready = 1'b0;
      o_w_awvalid   = 1'b0;
      o_w_wvalid    = 1'b0;
      o_w_bready    = 1'b0;
      o_w_arvalid   = 1'b0;
      o_w_rready    = 1'b0;
      o_w_rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Held low during reset so every ready/valid output reads zero.
            o_w_req_ready = ~i_w_areset;
            if (i_w_req_valid) begin
               addr_d  = i_w_req_addr;
               wdata_d = i_w_req_wdata;
               state_d = i_w_req_we ? StWrReq : StRdReq;
            end
         end
         StWrReq: begin
            o_w_awvalid = ~aw_done_q;
            o_w_wvalid  = ~w_done_q;
            aw_done_d   = aw_done_q | i_w_awready;
            w_done_d    = w_done_q | i_w_wready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = StWrResp;
            end
         end
         StWrResp: begin
            o_w_bready = 1'b1;
            if (i_w_bvalid) begin
               resp_d  = i_w_bresp;
               rdata_d = '0;
               state_d = StRsp;
            end else if (timeout) begin
               resp_d  = 2'b11;
               rdata_d = '0;
               state_d = StRsp;
            end
         end
         StRdReq: begin
            o_w_arvalid = 1'b1;
            if (i_w_arready) begin
               state_d = StRdData;
            end
         end
         StRdData: begin
            o_w_rready = 1'b1;
            if (i_w_rvalid) begin
               resp_d  = i_w_rresp;
               rdata_d = i_w_rdata;
               state_d = StRsp;
            end else if (timeout) begin
               resp_d  = 2'b11;
               rdata_d = '0;
               state_d = StRsp;
            end
         end
         StRsp: begin
            o_w_rsp_valid = 1'b1;
            if (i_w_rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_w_aclk) begin
      if (i_w_areset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

endmodule

// File: tb/tb_req2axi_master.sv
// Scoreboard bench for req2axi_master: requests go to a memory-backed AXI4-Lite slave model,
// expected responses come from a reference memory updated in issue order.
module tb_req2axi_master;

   localparam int TMO = 8;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  resp;
      logic [31:0] rdata;
      longint      acc;
      int          lat;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   req2axi_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_w_aclk     (clk),
      .i_w_areset   (rst),
      .i_w_req_valid(req_valid),
      .o_w_req_ready(req_ready),
      .i_w_req_we   (req_we),
      .i_w_req_addr (req_addr),
      .i_w_req_wdata(req_wdata),
      .o_w_rsp_valid(rsp_valid),
      .i_w_rsp_ready(rsp_ready),
      .o_w_rsp_resp (rsp_resp),
      .o_w_rsp_rdata(rsp_rdata),
      .o_w_awvalid  (awvalid),
      .i_w_awready  (awready),
      .o_w_awaddr   (awaddr),
      .o_w_wvalid   (wvalid),
      .i_w_wready   (wready),
      .o_w_wdata    (wdata),
      .i_w_bvalid   (bvalid),
      .o_w_bready   (bready),
      .i_w_bresp    (bresp),
      .o_w_arvalid  (arvalid),
      .i_w_arready  (arready),
      .o_w_araddr   (araddr),
      .i_w_rvalid   (rvalid),
      .o_w_rready   (rready),
      .i_w_rresp    (rresp),
      .i_w_rdata    (rdata)
   );

   txn_t        exp_q[$];
   txn_t        slv_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] slv_mem[logic [31:0]];
   int          n_checks = 0;
   int          n_errs = 0;
   longint      cyc = 0;
   int          smode = 0;     // 0 zero-wait, 1 random, 2 wready lags awready, 3 never respond
   int          rr_mode = 0;   // 0 always ready, 1 random, 2 hold low 5 cycles
   bit          slv_abort = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name);
      n_checks++;
      n_errs++;
      $display("FAIL %s: got no matching event, expected one", name);
   endfunction

   function automatic int slv_dly();
      if (smode == 1) return $urandom_range(0, 3);
      if (smode == 3) return 100000;
      return 0;
   endfunction

   // Slave model: observe handshakes at negedge, drive new values just after posedge.
   bit          s_aw_seen, s_w_seen, s_wr_stored, s_b_pend, s_r_pend, s_b_fire, s_r_fire, s_rst;
   int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_dly, s_r_dly, s_lag;
   logic [31:0] s_waddr, s_wdat, s_raddr;

   initial begin
      {awready, wready, arready, bvalid, rvalid} = '0;
      bresp = '0; rresp = '0; rdata = '0;
      {s_aw_seen, s_w_seen, s_wr_stored, s_b_pend, s_r_pend} = '0;
      s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_b_dly = 0; s_r_dly = 0; s_lag = 0;
      forever begin
         @(negedge clk);
         s_b_fire = 0;
         s_r_fire = 0;
         s_rst    = rst || slv_abort;
         if (s_rst) begin
            {s_aw_seen, s_w_seen, s_wr_stored, s_b_pend, s_r_pend} = '0;
            s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_lag = 0;
            if (slv_abort) begin
               slv_q.delete();
               slv_abort = 0;
            end
         end else begin
            if (s_aw_seen && !s_w_seen) check("aw_drop_w_hold", {awvalid, wvalid}, 2'b01);
            if (s_w_seen && !s_aw_seen) check("w_drop_aw_hold", {awvalid, wvalid}, 2'b10);
            if (awvalid && awready) begin
               s_aw_cnt++; s_aw_seen = 1; s_waddr = awaddr;
               if (slv_q.size() > 0) check("awaddr", awaddr, slv_q[0].addr);
               else fail("aw_unexpected");
            end
            if (wvalid && wready) begin
               s_w_cnt++; s_w_seen = 1; s_wdat = wdata;
               if (slv_q.size() > 0) check("wdata", wdata, slv_q[0].wdata);
               else fail("w_unexpected");
            end
            if (s_aw_seen && s_w_seen && !s_wr_stored) begin
               slv_mem[s_waddr] = s_wdat;
               s_wr_stored = 1; s_b_pend = 1; s_b_dly = slv_dly();
            end
            if (bvalid && bready) begin
               s_b_fire = 1;
               check("aw_count", s_aw_cnt, 1);
               check("w_count", s_w_cnt, 1);
               if (slv_q.size() > 0) void'(slv_q.pop_front());
               {s_aw_seen, s_w_seen, s_wr_stored, s_b_pend} = '0;
               s_aw_cnt = 0; s_w_cnt = 0; s_lag = 0;
            end
            if (arvalid && arready) begin
               s_ar_cnt++; s_raddr = araddr;
               if (slv_q.size() > 0) check("araddr", araddr, slv_q[0].addr);
               else fail("ar_unexpected");
               if (!s_r_pend) begin
                  s_r_pend = 1; s_r_dly = slv_dly();
               end
            end
            if (rvalid && rready) begin
               s_r_fire = 1;
               check("ar_count", s_ar_cnt, 1);
               if (slv_q.size() > 0) void'(slv_q.pop_front());
               s_ar_cnt = 0; s_r_pend = 0;
            end
         end
         @(posedge clk);
         #1;
         if (s_rst) begin
            {awready, wready, arready, bvalid, rvalid} = '0;
            bresp = '0; rresp = '0; rdata = '0;
         end else begin
            if (smode == 2 && s_aw_seen) s_lag++;
            awready = (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (smode == 1) wready = 1'($urandom_range(0, 1));
            else if (smode == 2) wready = (s_lag >= 4);
            else wready = 1'b1;
            if (s_b_fire) bvalid = 1'b0;
            else if (s_b_pend && !bvalid) begin
               if (s_b_dly == 0) begin
                  bvalid = 1'b1; bresp = slv_q[0].resp;
               end else s_b_dly--;
            end
            if (s_r_fire) rvalid = 1'b0;
            else if (s_r_pend && !rvalid) begin
               if (s_r_dly == 0) begin
                  rvalid = 1'b1; rresp = slv_q[0].resp;
                  rdata  = slv_mem.exists(s_raddr) ? slv_mem[s_raddr] : dflt(s_raddr);
               end else s_r_dly--;
            end
         end
      end
   end

   int low_cnt = 0;
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rr_mode == 0) rsp_ready = 1'b1;
         else if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
         else if (rsp_valid) begin
            if (low_cnt < 5) begin
               rsp_ready = 1'b0; low_cnt++;
            end else rsp_ready = 1'b1;
         end else begin
            low_cnt = 0; rsp_ready = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard whenever a response is consumed.
   bit          m_pend = 0;
   int          m_held = 0;
   logic [1:0]  m_resp;
   logic [31:0] m_rdata;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_pend = 0; m_held = 0;
         end else if (rsp_valid) begin
            check("req_ready_in_rsp", req_ready, 1'b0);
            if (exp_q.size() == 0) begin
               fail("rsp_unexpected");
               m_pend = 0;
            end else begin
               if (m_pend) check("rsp_stable", {rsp_resp, rsp_rdata}, {m_resp, m_rdata});
               else if (exp_q[0].lat > 0) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
               if (rsp_ready) begin
                  check("rsp_resp", rsp_resp, exp_q[0].resp);
                  check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                  if (rr_mode == 2) check("rsp_hold_cycles", m_held, 5);
                  void'(exp_q.pop_front());
                  m_pend = 0; m_held = 0;
               end else begin
                  m_pend = 1; m_held++;
                  m_resp = rsp_resp; m_rdata = rsp_rdata;
               end
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int lat);
      txn_t t;
      bit   ok = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1;
      end
      if (!ok) fail("req_accept_timeout");
      else begin
         t.we = we; t.addr = addr; t.wdata = data; t.resp = resp; t.acc = cyc; t.lat = lat;
         t.rdata = we ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr));
         if (we) ref_mem[addr] = data;
         exp_q.push_back(t);
         slv_q.push_back(t);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         fail("drain_timeout");
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'h0);
      check("rst_rsp", {rsp_resp, rsp_rdata}, 34'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_outs", {req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid},
            7'b1000000);

      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b00, 3);
      issue(1'b0, 32'h10, 32'h0, 2'b00, 3);
      drain();

      smode = 2;
      issue(1'b1, 32'h20, 32'h1357_9BDF, 2'b01, 0);
      drain();

      smode = 0; rr_mode = 2;
      issue(1'b0, 32'h10, 32'h0, 2'b10, 0);
      drain();

      smode = 1; rr_mode = 1;
      for (int n = 0; n < 40; n++) begin
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 4, $urandom,
               2'($urandom_range(0, 3)), 0);
      end
      drain();

      // Reset while waiting on read data: the transaction must vanish without a response.
      smode = 3; rr_mode = 0;
      issue(1'b0, 32'h10, 32'h0, 2'b00, 0);
      begin
         bit seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (rready) seen = 1;
         end
         if (!seen) fail("rd_data_wait");
      end
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      slv_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("midrst_outs", {req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'h0);
      check("midrst_rsp", {rsp_resp, rsp_rdata}, 34'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      smode = 0;
      issue(1'b1, 32'h44, 32'hCAFE_F00D, 2'b00, 3);
      issue(1'b0, 32'h44, 32'h0, 2'b01, 3);
      drain();
      repeat (5) @(negedge clk);

`ifdef REQ2AXI_TIMEOUT_EN
      smode = 3;
      issue(1'b1, 32'h40, 32'h0BAD_CAFE, 2'b11, TMO + 2);
      drain();
      slv_abort = 1;
      repeat (3) @(posedge clk);
      smode = 0;
      issue(1'b0, 32'h40, 32'h0, 2'b00, 3);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "simulation time limit");
   end

endmodule
